inst_fetch: RTL and testbench

Instruction fetch stage for the single-cycle MIPS CPU. It owns the program counter and fetches one word per instruction from instruction memory over a req/ack handshake. It holds the instruction stable for the decode controller, then computes the next PC from the controller's `pc_src`, the ALU zero flag and instruction fields. It stalls the core on slow memory and flags fetch faults.

---
 rtl/inst_fetch.sv | 74 +++++++
 tb/tb_inst_fetch.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// inst_fetch: MIPS fetch stage (PC, imem req/ack, timeout/misalign fault); `FETCH_STAT_EN adds retire/stall counters
`timescale 1ns/1ps
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [2:0]  pc_src,
  input  logic        alu_zero,
  input  logic [31:0] jr_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        fetch_err
`ifdef FETCH_STAT_EN
  ,
  output logic [31:0] stat_retired,
  output logic [31:0] stat_stall
`endif
);
  typedef enum logic [1:0] {FETCH, READY, ERR} state_t;
  state_t state, state_n;
  logic [7:0] cnt;
  logic [31:0] next_pc, br_pc;
  logic take_br, aligned, retire;
  assign pc_plus4 = pc + 32'd4;
  assign br_pc = pc_plus4 + {{14{inst[15]}}, inst[15:0], 2'b00};
  assign take_br = (pc_src == 3'd3 && alu_zero) || (pc_src == 3'd4 && !alu_zero);
  assign next_pc = pc_src == 3'd1 ? {pc_plus4[31:28], inst[25:0], 2'b00} :
                   pc_src == 3'd2 ? jr_addr :
                   take_br ? br_pc : pc_plus4;
  assign aligned = next_pc[1:0] == 2'b00;
  assign retire = state == READY && en && aligned;
  assign imem_req = state == FETCH && !rst;
  assign imem_addr = pc;
  assign inst_valid = state == READY && !rst;
  assign fetch_err = state == ERR && !rst;
  always_comb begin
    state_n = state;
    state_n = state == FETCH ? (imem_ack ? READY : (cnt + 8'd1 == 8'(TIMEOUT)) ? ERR : FETCH) :
              state == READY ? (en ? (aligned ? FETCH : ERR) : READY) : ERR;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc <= RESET_PC;
      inst <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      if (state == FETCH) cnt <= imem_ack ? 8'd0 : cnt + 8'd1;
      if (state == FETCH && imem_ack) inst <= imem_data;
      if (retire) pc <= next_pc;
    end
  end
`ifdef FETCH_STAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_retired <= '0;
      stat_stall <= '0;
    end else begin
      if (retire) stat_retired <= stat_retired + 32'd1;
      if (state == FETCH && !imem_ack) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: randomized bench for inst_fetch against a behavioural PC/memory model
`timescale 1ns/1ps
module tb_inst_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  logic clk = 0, rst = 1, en = 0, alu_zero = 0, imem_ack = 0;
  logic [2:0] pc_src = 0;
  logic [31:0] jr_addr = 0, imem_data = 0;
  logic imem_req, inst_valid, fetch_err;
  logic [31:0] imem_addr, pc, pc_plus4, inst;
`ifdef FETCH_STAT_EN
  logic [31:0] stat_retired, stat_stall;
`endif
  int vectors = 0, miscompares = 0;
  int mem_wait = 0, wcnt = 0;
  bit mem_off = 0, stray = 0, mem_rand = 0;
  logic [31:0] mpc = 0;
  logic [31:0] mem [logic [31:0]];

  inst_fetch #(.RESET_PC(RESET_PC), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .en(en), .pc_src(pc_src), .alu_zero(alu_zero), .jr_addr(jr_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .pc(pc), .pc_plus4(pc_plus4), .inst(inst), .inst_valid(inst_valid), .fetch_err(fetch_err)
`ifdef FETCH_STAT_EN
    , .stat_retired(stat_retired), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return mem_rand ? (a >> 2) * 32'h9E37_79B9 + 32'h1234_5677 : a >> 2;
  endfunction

  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] i,
                                           input logic [2:0] s, input logic z, input logic [31:0] j);
    logic [31:0] seq, br;
    int off;
    seq = p + 4;
    off = $signed(i[15:0]);
    br = seq + 32'(off * 4);
    case (s)
      3'd1: return (seq & 32'hF000_0000) | ((i & 32'h03FF_FFFF) * 4);
      3'd2: return j;
      3'd3: return z ? br : seq;
      3'd4: return z ? seq : br;
      default: return seq;
    endcase
  endfunction

  initial forever begin
    @(negedge clk);
    #1;
    if (stray) begin
      imem_ack = 1;
      imem_data = 32'hDEAD_BEEF;
    end else if (imem_req && !mem_off) begin
      if (wcnt >= mem_wait) begin
        imem_ack = 1;
        imem_data = mem_rd(imem_addr);
        wcnt = 0;
      end else begin
        imem_ack = 0;
        wcnt++;
      end
    end else begin
      imem_ack = 0;
      wcnt = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1; en = 0; stray = 0; mem_off = 0;
    @(negedge clk);
    vectors++;
    if (pc !== RESET_PC || inst !== 32'h0 || imem_req !== 1'b0 || inst_valid !== 1'b0 || fetch_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: pc=%h inst=%h req=%b valid=%b err=%b, required %h 0 0 0 0", pc, inst, imem_req, inst_valid, fetch_err, RESET_PC);
    end
    rst = 0;
    mpc = RESET_PC;
    #1;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      miscompares++;
      $display("FAIL req_after_reset: req=%b addr=%h, required 1 %h", imem_req, imem_addr, RESET_PC);
    end
  endtask

  task automatic do_inst(input logic [2:0] src, input logic z, input logic [31:0] j, input int hold, output int lat);
    logic [31:0] cur, nxt;
    lat = 0;
    while (!inst_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    vectors++;
    if (inst_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL valid_wait: inst_valid=%b after %0d cycles, required 1", inst_valid, lat);
    end
    cur = mem_rd(mpc);
    for (int k = 0; k <= hold; k++) begin
      vectors++;
      if (pc !== mpc || inst !== cur || pc_plus4 !== mpc + 32'd4 || imem_req !== 1'b0 || fetch_err !== 1'b0) begin
        miscompares++;
        $display("FAIL held_inst: pc=%h inst=%h pc4=%h req=%b err=%b, required %h %h %h 0 0", pc, inst, pc_plus4, imem_req, fetch_err, mpc, cur, mpc + 32'd4);
      end
      if (k < hold) @(negedge clk);
    end
    nxt = ref_next(mpc, cur, src, z, j);
    pc_src = src; alu_zero = z; jr_addr = j; en = 1;
    @(negedge clk);
    en = 0;
    if (nxt[1:0] != 2'b00) begin
      vectors++;
      if (fetch_err !== 1'b1 || pc !== mpc || inst_valid !== 1'b0 || imem_req !== 1'b0) begin
        miscompares++;
        $display("FAIL misaligned: err=%b pc=%h valid=%b req=%b, required 1 %h 0 0", fetch_err, pc, inst_valid, imem_req, mpc);
      end
    end else begin
      mpc = nxt;
      vectors++;
      if (imem_req !== 1'b1 || imem_addr !== nxt || inst_valid !== 1'b0 || fetch_err !== 1'b0) begin
        miscompares++;
        $display("FAIL next_fetch: req=%b addr=%h valid=%b err=%b, required 1 %h 0 0", imem_req, imem_addr, inst_valid, fetch_err, nxt);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    mem_wait = 5;
    repeat (2) @(negedge clk);
    vectors++;
    if (imem_req !== 1'b1 || inst_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_pending: req=%b valid=%b, required 1 0", imem_req, inst_valid);
    end
    rst = 1; stray = 1;
    @(negedge clk);
    stray = 0;
    vectors++;
    if (pc !== RESET_PC || inst !== 32'h0 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_fetch_reset: pc=%h inst=%h req=%b valid=%b, required %h 0 0 0", pc, inst, imem_req, inst_valid, RESET_PC);
    end
    rst = 0; mem_wait = 0; mpc = RESET_PC;
  endtask

  task automatic test_sequential();
    int lat;
    do_reset();
    mem_wait = 0; mem_rand = 0;
    for (int i = 0; i < 6; i++) begin
      do_inst(3'd0, 1'b0, 32'h0, 0, lat);
      vectors++;
      if (lat !== 1) begin
        miscompares++;
        $display("FAIL zero_wait_latency: %0d cycles to inst_valid, required 1", lat);
      end
    end
  endtask

  task automatic test_wait_hold();
    int lat;
    mem_wait = 3;
    do_inst(3'd0, 1'b0, 32'h0, 0, lat);
    for (int i = 0; i < 2; i++) begin
      do_inst(3'd0, 1'b0, 32'h0, 5, lat);
      vectors++;
      if (lat !== 4) begin
        miscompares++;
        $display("FAIL wait3_latency: %0d cycles to inst_valid, required 4", lat);
      end
    end
    mem_wait = 0;
  endtask

  task automatic test_branch();
    logic [2:0] srcs [4] = '{3'd3, 3'd3, 3'd4, 3'd4};
    logic zs [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] exps [4] = '{32'h0FC, 32'h104, 32'h0FC, 32'h104};
    int lat;
    mem[32'h100] = 32'h1000_FFFE;
    for (int i = 0; i < 4; i++) begin
      do_inst(3'd2, 1'b0, 32'h100, 0, lat);
      do_inst(srcs[i], zs[i], 32'h0, 0, lat);
      vectors++;
      if (imem_addr !== exps[i]) begin
        miscompares++;
        $display("FAIL branch_target[%0d]: addr=%h, required %h", i, imem_addr, exps[i]);
      end
    end
  endtask

  task automatic test_jump_jr();
    int lat;
    mem[32'h4000_0010] = 32'h0800_0040;
    do_inst(3'd2, 1'b0, 32'h4000_0010, 0, lat);
    do_inst(3'd1, 1'b0, 32'h0, 0, lat);
    vectors++;
    if (imem_addr !== 32'h4000_0100) begin
      miscompares++;
      $display("FAIL jump_target: addr=%h, required 40000100", imem_addr);
    end
    do_inst(3'd2, 1'b0, 32'hFFFF_FFFC, 0, lat);
    do_inst(3'd0, 1'b0, 32'h0, 0, lat);
    vectors++;
    if (imem_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL pc_wrap: addr=%h, required 00000000", imem_addr);
    end
    do_inst(3'd2, 1'b0, 32'h4000_0010, 0, lat);
    do_inst(3'd2, 1'b0, 32'h202, 0, lat);
    stray = 1;
    repeat (3) @(negedge clk);
    stray = 0;
    vectors++;
    if (fetch_err !== 1'b1 || pc !== 32'h4000_0010 || inst !== 32'h0800_0040 || inst_valid !== 1'b0 || imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL jr_misaligned_err: err=%b pc=%h inst=%h valid=%b req=%b, required 1 40000010 08000040 0 0", fetch_err, pc, inst, inst_valid, imem_req);
    end
  endtask

  task automatic test_timeout();
    int lat;
    do_reset();
    mem_off = 1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      vectors++;
      if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin
        miscompares++;
        $display("FAIL timeout_early[%0d]: req=%b err=%b, required 1 0", k, imem_req, fetch_err);
      end
    end
    @(negedge clk);
    vectors++;
    if (fetch_err !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_err: err=%b req=%b valid=%b, required 1 0 0", fetch_err, imem_req, inst_valid);
    end
    mem_off = 0; stray = 1;
    repeat (2) @(negedge clk);
    stray = 0;
    vectors++;
    if (fetch_err !== 1'b1 || inst_valid !== 1'b0 || inst !== 32'h0) begin
      miscompares++;
      $display("FAIL late_ack: err=%b valid=%b inst=%h, required 1 0 0", fetch_err, inst_valid, inst);
    end
    do_reset();
    mem_wait = 15;
    do_inst(3'd0, 1'b0, 32'h0, 0, lat);
    vectors++;
    if (lat !== 16) begin
      miscompares++;
      $display("FAIL ack_at_limit: %0d cycles to inst_valid, required 16", lat);
    end
    mem_wait = 0;
  endtask

`ifdef FETCH_STAT_EN
  task automatic test_stats();
    int lat;
    do_reset();
    mem_wait = 2;
    for (int i = 0; i < 10; i++) do_inst(3'd0, 1'b0, 32'h0, 0, lat);
    vectors++;
    if (stat_retired !== 32'd10 || stat_stall !== 32'd20) begin
      miscompares++;
      $display("FAIL stats: retired=%0d stall=%0d, required 10 20", stat_retired, stat_stall);
    end
    mem_wait = 0;
  endtask
`endif

  task automatic test_random();
    int lat;
    do_reset();
    mem_rand = 1;
    for (int i = 0; i < 200; i++) begin
      mem_wait = $urandom_range(0, 3);
      do_inst(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom_range(0, 2), lat);
    end
    mem_rand = 0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wait_hold();
    test_branch();
    test_jump_jr();
    test_timeout();
`ifdef FETCH_STAT_EN
    test_stats();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
